// File: rtl/piezo_scheduler_if.sv
// Controller-side bundle of the piezo scheduler: play/key requests in,
// note output, playback status and key handshake pulses out.
interface piezo_scheduler_if;
    logic        play_start;
    logic [31:0] seq_data;
    logic [2:0]  seq_len;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  piezo_out;
    logic [3:0]  led_out;
    logic [2:0]  note_index;
    logic        busy;
    logic        play_done;
    logic        key_accept;
    logic        key_reject;

    modport master (
        output play_start, seq_data, seq_len, key_valid, key_code,
        input  piezo_out, led_out, note_index, busy, play_done, key_accept, key_reject
    );

    modport slave (
        input  play_start, seq_data, seq_len, key_valid, key_code,
        output piezo_out, led_out, note_index, busy, play_done, key_accept, key_reject
    );
endinterface

// File: rtl/piezo_scheduler.sv
// Melody sequencer and key-echo arbiter driving the shared piezo/LED note output.
// Every output comes straight from a register updated with its next-cycle value.
module piezo_scheduler #(
    parameter int NOTE_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int ECHO_CYCLES = 6
) (
    input logic              clk,
    input logic              reset_n,
    piezo_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2,
        ECHO = 2'd3
    } state_t;

    localparam logic [15:0] NOTE_LAST = 16'(NOTE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] ECHO_LAST = 16'(ECHO_CYCLES - 1);

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [31:0] data_r, data_s;
    logic [2:0]  len_r, len_s;
    logic [3:0]  key_r, key_s;
    logic [3:0]  piezo_r, piezo_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        accept_r, accept_s;
    logic        reject_r, reject_s;

    function automatic logic [3:0] get_nibble(input logic [31:0] data, input logic [2:0] idx);
        return data[{idx, 2'b00} +: 4];
    endfunction

    // Next-state, next-output and shadow-register logic for all four states.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r + 16'd1;
        idx_s    = idx_r;
        data_s   = data_r;
        len_s    = len_r;
        key_s    = key_r;
        piezo_s  = piezo_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        accept_s = 1'b0;
        reject_s = 1'b0;
        case (state_r)
            IDLE, ECHO: begin
                if (bus.play_start) begin
                    // Playback wins over a simultaneous key press and aborts an echo.
                    state_s  = NOTE;
                    cnt_s    = 16'd0;
                    idx_s    = 3'd0;
                    data_s   = bus.seq_data;
                    len_s    = bus.seq_len;
                    piezo_s  = get_nibble(bus.seq_data, 3'd0);
                    busy_s   = 1'b1;
                    reject_s = bus.key_valid;
                end else if (bus.key_valid) begin
                    state_s  = ECHO;
                    cnt_s    = 16'd0;
                    key_s    = bus.key_code;
                    piezo_s  = bus.key_code;
                    busy_s   = 1'b0;
                    accept_s = 1'b1;
                end else if (state_r == ECHO && cnt_r != ECHO_LAST) begin
                    piezo_s = key_r;
                    busy_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                    cnt_s   = 16'd0;
                    piezo_s = 4'd0;
                    busy_s  = 1'b0;
                end
            end
            NOTE: begin
                reject_s = bus.key_valid;
                if (cnt_r == NOTE_LAST) begin
                    state_s = GAP;
                    cnt_s   = 16'd0;
                    piezo_s = 4'd0;
                end else begin
                    piezo_s = get_nibble(data_r, idx_r);
                end
            end
            GAP: begin
                reject_s = bus.key_valid;
                piezo_s  = 4'd0;
                if (cnt_r == GAP_LAST) begin
                    cnt_s = 16'd0;
                    if (idx_r == len_r) begin
                        state_s = IDLE;
                        idx_s   = 3'd0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = NOTE;
                        idx_s   = idx_r + 3'd1;
                        piezo_s = get_nibble(data_r, idx_r + 3'd1);
                    end
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 16'd0;
                idx_s   = 3'd0;
                piezo_s = 4'd0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counter, shadow and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= 16'd0;
            idx_r    <= 3'd0;
            data_r   <= 32'd0;
            len_r    <= 3'd0;
            key_r    <= 4'd0;
            piezo_r  <= 4'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            accept_r <= 1'b0;
            reject_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            data_r   <= data_s;
            len_r    <= len_s;
            key_r    <= key_s;
            piezo_r  <= piezo_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            accept_r <= accept_s;
            reject_r <= reject_s;
        end
    end

    assign bus.piezo_out  = piezo_r;
    assign bus.led_out    = piezo_r;
    assign bus.note_index = idx_r;
    assign bus.busy       = busy_r;
    assign bus.play_done  = done_r;
    assign bus.key_accept = accept_r;
    assign bus.key_reject = reject_r;
endmodule

// File: tb/tb_piezo_scheduler.sv
// Directed self-checking bench for piezo_scheduler; cycle k is observed 1 time
// unit after the k-th rising edge following the request edge.
module tb_piezo_scheduler;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    piezo_scheduler_if bus();

    piezo_scheduler #(
        .NOTE_CYCLES(8),
        .GAP_CYCLES (4),
        .ECHO_CYCLES(6)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.play_start = 1'b0; bus.key_valid = 1'b0;
        bus.seq_data = 32'd0; bus.seq_len = 3'd0; bus.key_code = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.piezo_out, bus.led_out, bus.note_index, bus.busy, bus.play_done,
             bus.key_accept, bus.key_reject} !== 15'd0) begin
            errors++;
            $display("FAIL reset_init got %0h exp 0", {bus.piezo_out, bus.led_out,
                     bus.note_index, bus.busy, bus.play_done, bus.key_accept, bus.key_reject});
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({bus.piezo_out, bus.busy} !== 5'd0) begin
            errors++; $display("FAIL reset_release got %0h exp 0", {bus.piezo_out, bus.busy});
        end
        // Run into note 1 of a melody, then reset between clock edges.
        bus.seq_data = 32'h87654321; bus.seq_len = 3'd2; bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        repeat (13) tick();
        checks++;
        if ({bus.piezo_out, bus.note_index, bus.busy} !== {4'd2, 3'd1, 1'b1}) begin
            errors++; $display("FAIL reset_pre_note got %0h exp %0h",
                               {bus.piezo_out, bus.note_index, bus.busy}, {4'd2, 3'd1, 1'b1});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.piezo_out, bus.led_out, bus.note_index, bus.busy, bus.play_done,
             bus.key_accept, bus.key_reject} !== 15'd0) begin
            errors++;
            $display("FAIL reset_async got %0h exp 0", {bus.piezo_out, bus.led_out,
                     bus.note_index, bus.busy, bus.play_done, bus.key_accept, bus.key_reject});
        end
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.piezo_out, bus.note_index, bus.busy, bus.play_done} !== 9'd0) begin
                errors++; $display("FAIL reset_after k %0d got %0h exp 0", k,
                                   {bus.piezo_out, bus.note_index, bus.busy, bus.play_done});
            end
        end
    endtask

    task automatic test_melody();
        logic [31:0] data;
        logic [3:0]  exp_piezo;
        logic [2:0]  exp_idx;
        logic        exp_busy, exp_done;
        int          slot, pos;
        data = 32'h87654321;
        bus.seq_data = data; bus.seq_len = 3'd2; bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        for (int c = 1; c <= 37; c++) begin
            if (c > 1) tick();
            slot = (c - 1) / 12;
            pos  = (c - 1) % 12;
            exp_piezo = (c <= 36 && pos < 8) ? data[slot*4 +: 4] : 4'd0;
            exp_idx   = (c <= 36) ? slot[2:0] : 3'd0;
            exp_busy  = (c <= 36);
            exp_done  = (c == 37);
            checks++;
            if ({bus.piezo_out, bus.led_out, bus.note_index, bus.busy, bus.play_done} !==
                {exp_piezo, exp_piezo, exp_idx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL melody cyc %0d got p%0h l%0h i%0d b%0b d%0b exp p%0h i%0d b%0b d%0b",
                         c, bus.piezo_out, bus.led_out, bus.note_index, bus.busy, bus.play_done,
                         exp_piezo, exp_idx, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_full_length();
        logic [31:0] data;
        logic [3:0]  exp_piezo;
        logic [2:0]  exp_idx;
        logic        exp_busy, exp_done;
        int          slot, pos;
        data = 32'h0F0F0F0F;
        bus.seq_data = data; bus.seq_len = 3'd7; bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        bus.seq_data = 32'hFFFFFFFF; bus.seq_len = 3'd0;
        for (int c = 1; c <= 97; c++) begin
            if (c > 1) tick();
            slot = (c - 1) / 12;
            pos  = (c - 1) % 12;
            exp_piezo = (c <= 96 && pos < 8) ? data[slot*4 +: 4] : 4'd0;
            exp_idx   = (c <= 96) ? slot[2:0] : 3'd0;
            exp_busy  = (c <= 96);
            exp_done  = (c == 97);
            checks++;
            if ({bus.piezo_out, bus.led_out, bus.note_index, bus.busy, bus.play_done} !==
                {exp_piezo, exp_piezo, exp_idx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL full_len cyc %0d got p%0h l%0h i%0d b%0b d%0b exp p%0h i%0d b%0b d%0b",
                         c, bus.piezo_out, bus.led_out, bus.note_index, bus.busy, bus.play_done,
                         exp_piezo, exp_idx, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Still in the play_done cycle of the previous melody.
        bus.seq_data = 32'h00000007; bus.seq_len = 3'd0; bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        checks++;
        if ({bus.piezo_out, bus.busy, bus.play_done} !== {4'd7, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_start got %0h exp %0h",
                               {bus.piezo_out, bus.busy, bus.play_done}, {4'd7, 1'b1, 1'b0});
        end
        repeat (11) tick();
        checks++;
        if ({bus.piezo_out, bus.busy, bus.play_done} !== {4'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_gap got %0h exp %0h",
                               {bus.piezo_out, bus.busy, bus.play_done}, {4'd0, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if ({bus.piezo_out, bus.busy, bus.play_done} !== {4'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL b2b_done got %0h exp %0h",
                               {bus.piezo_out, bus.busy, bus.play_done}, {4'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_echo();
        logic [3:0] exp_piezo;
        logic       exp_acc;
        bus.key_code = 4'd5; bus.key_valid = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) tick();
            bus.key_valid = 1'b0;
            exp_piezo = (c <= 3) ? 4'd5 : (c <= 9) ? 4'd9 : 4'd0;
            exp_acc   = (c == 1 || c == 4);
            checks++;
            if ({bus.piezo_out, bus.led_out, bus.key_accept, bus.key_reject, bus.busy} !==
                {exp_piezo, exp_piezo, exp_acc, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL echo cyc %0d got p%0h l%0h a%0b r%0b b%0b exp p%0h a%0b",
                         c, bus.piezo_out, bus.led_out, bus.key_accept, bus.key_reject,
                         bus.busy, exp_piezo, exp_acc);
            end
            if (c == 3) begin
                bus.key_code = 4'd9; bus.key_valid = 1'b1;
            end
        end
    endtask

    task automatic test_rejection();
        bus.seq_data = 32'h87654321; bus.seq_len = 3'd0; bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        repeat (2) tick();
        bus.key_code = 4'd3; bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        checks++;
        if ({bus.piezo_out, bus.key_reject, bus.key_accept, bus.busy} !==
            {4'd1, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rej_note got %0h exp %0h",
                               {bus.piezo_out, bus.key_reject, bus.key_accept, bus.busy},
                               {4'd1, 1'b1, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if ({bus.piezo_out, bus.key_reject} !== {4'd1, 1'b0}) begin
            errors++; $display("FAIL rej_pulse_end got %0h exp %0h",
                               {bus.piezo_out, bus.key_reject}, {4'd1, 1'b0});
        end
        repeat (8) tick();
        checks++;
        if ({bus.play_done, bus.busy} !== 2'b10) begin
            errors++; $display("FAIL rej_done got %0b exp 10", {bus.play_done, bus.busy});
        end
        // Simultaneous play_start and key_valid in IDLE.
        bus.seq_data = 32'h00000004; bus.seq_len = 3'd0;
        bus.play_start = 1'b1; bus.key_code = 4'hC; bus.key_valid = 1'b1;
        tick();
        bus.play_start = 1'b0; bus.key_valid = 1'b0;
        checks++;
        if ({bus.piezo_out, bus.busy, bus.key_reject, bus.key_accept} !==
            {4'd4, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rej_simul got %0h exp %0h",
                               {bus.piezo_out, bus.busy, bus.key_reject, bus.key_accept},
                               {4'd4, 1'b1, 1'b1, 1'b0});
        end
        repeat (12) tick();
        checks++;
        if ({bus.play_done, bus.busy} !== 2'b10) begin
            errors++; $display("FAIL rej_simul_done got %0b exp 10", {bus.play_done, bus.busy});
        end
    endtask

    task automatic test_abort();
        bus.key_code = 4'd6; bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick();
        checks++;
        if ({bus.piezo_out, bus.busy} !== {4'd6, 1'b0}) begin
            errors++; $display("FAIL abort_echo got %0h exp %0h",
                               {bus.piezo_out, bus.busy}, {4'd6, 1'b0});
        end
        bus.seq_data = 32'h000000A2; bus.seq_len = 3'd1; bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        checks++;
        if ({bus.piezo_out, bus.led_out, bus.busy, bus.note_index} !==
            {4'd2, 4'd2, 1'b1, 3'd0}) begin
            errors++; $display("FAIL abort_start got %0h exp %0h",
                               {bus.piezo_out, bus.led_out, bus.busy, bus.note_index},
                               {4'd2, 4'd2, 1'b1, 3'd0});
        end
        repeat (8) tick();
        bus.seq_data = 32'h0000000F; bus.seq_len = 3'd0; bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        checks++;
        if ({bus.piezo_out, bus.busy, bus.note_index} !== {4'd0, 1'b1, 3'd0}) begin
            errors++; $display("FAIL abort_gap_ignore got %0h exp %0h",
                               {bus.piezo_out, bus.busy, bus.note_index}, {4'd0, 1'b1, 3'd0});
        end
        repeat (3) tick();
        checks++;
        if ({bus.piezo_out, bus.note_index} !== {4'hA, 3'd1}) begin
            errors++; $display("FAIL abort_note1 got %0h exp %0h",
                               {bus.piezo_out, bus.note_index}, {4'hA, 3'd1});
        end
        repeat (11) tick();
        checks++;
        if ({bus.piezo_out, bus.busy, bus.play_done} !== {4'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL abort_last_gap got %0h exp %0h",
                               {bus.piezo_out, bus.busy, bus.play_done}, {4'd0, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if ({bus.busy, bus.play_done, bus.note_index} !== {1'b0, 1'b1, 3'd0}) begin
            errors++; $display("FAIL abort_done got %0h exp %0h",
                               {bus.busy, bus.play_done, bus.note_index}, {1'b0, 1'b1, 3'd0});
        end
    endtask

    initial begin
        test_reset();
        test_melody();
        test_full_length();
        test_back_to_back();
        test_echo();
        test_rejection();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/piezo_scheduler.md
# piezo_scheduler

Sequencer and arbiter for the shared piezo/LED note output of the memory game. It plays a stored melody of up to eight 4-bit notes with fixed note and gap durations, and arbitrates the same output between melody playback and keypad-press echo. It sits between the game controller, which issues play requests and supplies the melody register, and the piezo/LED drivers. Key presses are rejected while a melody is playing.

## Interface
- NOTE_CYCLES, 8: clock cycles each melody note is driven; must be ≥1.
- GAP_CYCLES, 4: silent clock cycles after each note; must be ≥1.
- ECHO_CYCLES, 6: clock cycles a key-press echo is driven; must be ≥1.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- play_start  in  1  one-cycle request to start melody playback.
- seq_data  in  32  melody; note i at [4i+3:4i], note 0 at [3:0]; sampled on the accepted play_start.
- seq_len  in  3  index of the last note to play (0..7); sampled with seq_data.
- key_valid  in  1  one-cycle keypad press strobe.
- key_code  in  4  keypad value; sampled with key_valid.
- piezo_out  out  4  note code to piezo driver; 0 = silent.
- led_out  out  4  identical to piezo_out.
- note_index  out  3  index of the note currently playing or in its gap.
- busy  out  1  high while melody playback is in NOTE or GAP.
- play_done  out  1  one-cycle pulse when melody completes.
- key_accept  out  1  one-cycle pulse when a key press is echoed.
- key_reject  out  1  one-cycle pulse when a key press is dropped.

## Operation
- States: IDLE, NOTE, GAP, ECHO. The duration counter is 16 bits and is cleared on every state entry.
- Reset (reset_n=0, immediate): state=IDLE; all outputs are 0; shadow melody, shadow length, latched key and counter are cleared.
- IDLE: piezo/led are 0.
  - play_start: latch seq_data and seq_len; note_index=0; go to NOTE.
  - key_valid without play_start: latch key_code; go to ECHO; pulse key_accept.
  - play_start and key_valid in the same cycle: playback wins; pulse key_reject.
- NOTE: piezo/led = shadow nibble[note_index]. After NOTE_CYCLES cycles, go to GAP.
- GAP: piezo/led are 0.
  - After GAP_CYCLES cycles with note_index == length: go to IDLE, note_index=0, pulse play_done.
  - Otherwise: note_index+1 and go to NOTE.
- ECHO: piezo/led = latched key.
  - After ECHO_CYCLES cycles: go to IDLE.
  - key_valid: retrigger with the new code, clear the counter, pulse key_accept.
  - play_start: abort the echo and start playback exactly as from IDLE; play_start beats a simultaneous key_valid, which pulses key_reject.
- NOTE/GAP: play_start is ignored; playback is not restarted and the shadow registers are not reloaded. key_valid pulses key_reject; outputs are unaffected.
- A nibble of 0 occupies its full note slot silently.
- Changes to seq_data or seq_len after the accepted play_start have no effect.
- note_index cannot exceed 7. The increment happens only when note_index < length, so no wrap occurs.

## Timing
- All outputs are registered.
- Accepted play_start sampled at edge 0:
  - note 0 is on piezo/led in cycles 1..NOTE_CYCLES;
  - 0 in the next GAP_CYCLES cycles;
  - note i starts at cycle 1+i·(NOTE_CYCLES+GAP_CYCLES).
- busy is high in cycles 1..(L+1)(NOTE_CYCLES+GAP_CYCLES), where L = seq_len.
- play_done pulses, with busy=0, in cycle (L+1)(NOTE_CYCLES+GAP_CYCLES)+1.
- key_valid sampled at edge 0 in IDLE/ECHO: key_code is on outputs in cycles 1..ECHO_CYCLES; key_accept is high in cycle 1.
- key_reject is high in the cycle after the rejected key_valid.
- Back-to-back play_start in the cycle play_done is high is accepted (state is IDLE).

## Test plan
- Reset: assert reset_n=0 mid-NOTE → piezo/led/note_index/busy/pulses read 0 immediately. Release → IDLE, outputs stay 0.
- Melody: seq_data=0x87654321, seq_len=2, play_start at edge 0, default parameters →
  - piezo=1 in cycles 1–8, 0 in 9–12;
  - piezo=2 in 13–20, 0 in 21–24;
  - piezo=3 in 25–32, 0 in 33–36;
  - note_index 0/1/2; busy 1–36; play_done at cycle 37.
- Full length: seq_len=7, seq_data=0x0F0F0F0F → 8 slots with silent slots for the 0 notes; play_done at cycle 97; note_index returns to 0.
- Echo: key_valid code 5 in IDLE → piezo=led=5 in cycles 1–6, key_accept in cycle 1. Retrigger with 9 at edge 3 → 9 in cycles 4–9, then 0.
- Rejection: key_valid during NOTE → key_reject next cycle, note output unchanged. Simultaneous play_start and key_valid in IDLE → playback starts and key_reject pulses.
- Abort: play_start during ECHO at edge 2 → note 0 on outputs from cycle 3; busy=1; later play_start during GAP is ignored.
